// File: rtl/apb_master_ctrl.sv
// APB initiator: accepts single-beat commands, runs one SETUP/ACCESS transfer
// each, and returns read data and status on a response channel.
module apb_master_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt, cnt_inc;
  logic            tmo_hit, accept;

  // Bus strobes decode straight from the state register so an async reset
  // drops them immediately.
  assign PSELx     = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign RSP_VALID = (state == RESP);
  assign CMD_READY = (state == IDLE) && !PRESET;
  assign accept    = CMD_VALID && CMD_READY;

  assign cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + CW'(1);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || tmo_hit) state_nxt = RESP;
      RESP:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (accept) begin
        PWRITE   <= CMD_WRITE;
        PADDR    <= CMD_ADDR;
        PWDATA   <= CMD_WDATA;
        wait_cnt <= '0;
      end
      if (state == ACCESS) begin
        if (PREADY) begin
          RSP_RDATA   <= PWRITE ? '0 : PRDATA;
          RSP_ERR     <= PSLVERR;
          RSP_TIMEOUT <= 1'b0;
        end else begin
          wait_cnt <= cnt_inc;
          if (tmo_hit) begin
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b1;
            RSP_TIMEOUT <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: inputs driven and outputs checked on the
// falling edge; the APB slave is played directly by the stimulus.
module tb_apb_master_ctrl;
  localparam int AW = 32, DW = 32;

  logic          PCLK, PRESET;
  logic          CMD_VALID, CMD_READY, CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [DW-1:0] CMD_WDATA;
  logic          RSP_VALID, RSP_READY, RSP_ERR, RSP_TIMEOUT;
  logic [DW-1:0] RSP_RDATA;
  logic          PSELx, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int errors = 0;
  int checks = 0;

  apb_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic test_reset;
    PRESET = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
    RSP_READY = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT, CMD_READY} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 0000000",
        {PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT, CMD_READY});
    end
    checks++;
    if (PADDR !== '0 || PWDATA !== '0 || RSP_RDATA !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want 0", PADDR, PWDATA, RSP_RDATA);
    end
    PRESET = 1'b0;
    #1;
    checks++;
    if (CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_rel_ready: got %b want 1", CMD_READY); end
  endtask

  // Minimum latency write: accept cycle, SETUP, ACCESS, RESP on consecutive cycles.
  task automatic test_write;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h0; CMD_WDATA = 32'hA5A5_0001;
    PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
    checks++;
    if (CMD_READY !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", CMD_READY); end
    @(negedge PCLK);
    CMD_VALID = 1'b0;
    checks++;
    if ({PSELx, PENABLE, CMD_READY, PWRITE} !== 4'b1001 || PADDR !== 32'h0) begin
      errors++; $display("FAIL wr_setup: got sel/en/rdy/wr=%b addr=%h want 1001 0",
        {PSELx, PENABLE, CMD_READY, PWRITE}, PADDR);
    end
    @(negedge PCLK);
    checks++;
    if ({PSELx, PENABLE} !== 2'b11 || PWDATA !== 32'hA5A5_0001 || RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL wr_access: got sel/en=%b wdata=%h rv=%b want 11 a5a50001 0",
        {PSELx, PENABLE}, PWDATA, RSP_VALID);
    end
    @(negedge PCLK);
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_TIMEOUT !== 1'b0 || RSP_RDATA !== '0 ||
        PSELx !== 1'b0 || PENABLE !== 1'b0) begin
      errors++; $display("FAIL wr_resp: got rv=%b err=%b to=%b rdata=%h sel=%b en=%b want 1 0 0 0 0 0",
        RSP_VALID, RSP_ERR, RSP_TIMEOUT, RSP_RDATA, PSELx, PENABLE);
    end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
    checks++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1 || PWDATA !== 32'hA5A5_0001) begin
      errors++; $display("FAIL wr_idle: got rv=%b rdy=%b wdata=%h want 0 1 a5a50001",
        RSP_VALID, CMD_READY, PWDATA);
    end
  endtask

  task automatic test_read_wait;
    int en_cnt = 0;
    bit stable = 1'b1;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h4; PREADY = 1'b0; PRDATA = 32'h0;
    @(negedge PCLK);
    CMD_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (PENABLE === 1'b1 && PSELx === 1'b1) en_cnt++;
      if (PADDR !== 32'h4 || PWRITE !== 1'b0) stable = 1'b0;
      PREADY = (i == 3);
      PRDATA = (i == 3) ? 32'h0000_00C3 : 32'h1111_1111;
    end
    @(negedge PCLK);
    PREADY = 1'b0;
    checks++;
    if (en_cnt != 4 || !stable) begin
      errors++; $display("FAIL rd_wait_access: got en_cycles=%0d stable=%b want 4 1", en_cnt, stable);
    end
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h0000_00C3 || RSP_ERR !== 1'b0 || PENABLE !== 1'b0) begin
      errors++; $display("FAIL rd_wait_resp: got rv=%b rdata=%h err=%b en=%b want 1 000000c3 0 0",
        RSP_VALID, RSP_RDATA, RSP_ERR, PENABLE);
    end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
  endtask

  task automatic test_slverr;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h8; CMD_WDATA = 32'h1234_5678;
    @(negedge PCLK);
    CMD_VALID = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    PREADY = 1'b0; PSLVERR = 1'b0;
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_TIMEOUT !== 1'b0 || RSP_RDATA !== '0) begin
      errors++; $display("FAIL slverr_resp: got rv=%b err=%b to=%b rdata=%h want 1 1 0 0",
        RSP_VALID, RSP_ERR, RSP_TIMEOUT, RSP_RDATA);
    end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
  endtask

  task automatic test_timeout;
    int en_cnt = 0;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'hC; PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
    @(negedge PCLK);
    CMD_VALID = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK);
      if (PENABLE === 1'b1 && PSELx === 1'b1) en_cnt++;
    end
    checks++;
    if (en_cnt != 16) begin errors++; $display("FAIL tmo_access: got en_cycles=%0d want 16", en_cnt); end
    @(negedge PCLK);
    checks++;
    if (PSELx !== 1'b0 || PENABLE !== 1'b0 || RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 ||
        RSP_TIMEOUT !== 1'b1 || RSP_RDATA !== '0) begin
      errors++; $display("FAIL tmo_resp: got sel=%b en=%b rv=%b err=%b to=%b rdata=%h want 0 0 1 1 1 0",
        PSELx, PENABLE, RSP_VALID, RSP_ERR, RSP_TIMEOUT, RSP_RDATA);
    end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit held = 1'b1;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h10; CMD_WDATA = 32'hCAFE_0010;
    PREADY = 1'b1; PSLVERR = 1'b1;
    @(negedge PCLK);
    CMD_WRITE = 1'b0; CMD_ADDR = 32'h14; CMD_WDATA = 32'h0;
    @(negedge PCLK);
    @(negedge PCLK);
    PSLVERR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_TIMEOUT !== 1'b0 || RSP_RDATA !== '0 ||
          CMD_READY !== 1'b0 || PADDR !== 32'h10) held = 1'b0;
      @(negedge PCLK);
    end
    checks++;
    if (!held) begin errors++; $display("FAIL b2b_hold: got held=%b want 1", held); end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
    checks++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1 || PSELx !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got rv=%b rdy=%b sel=%b want 0 1 0", RSP_VALID, CMD_READY, PSELx);
    end
    PRDATA = 32'h0000_0055;
    @(negedge PCLK);
    CMD_VALID = 1'b0;
    checks++;
    if (PSELx !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h14 || PWRITE !== 1'b0) begin
      errors++; $display("FAIL b2b_setup2: got sel=%b en=%b addr=%h wr=%b want 1 0 14 0",
        PSELx, PENABLE, PADDR, PWRITE);
    end
    @(negedge PCLK);
    @(negedge PCLK);
    PREADY = 1'b0;
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h0000_0055 || RSP_ERR !== 1'b0) begin
      errors++; $display("FAIL b2b_resp2: got rv=%b rdata=%h err=%b want 1 00000055 0",
        RSP_VALID, RSP_RDATA, RSP_ERR);
    end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit no_rsp = 1'b1;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h20; PREADY = 1'b0;
    @(negedge PCLK);
    CMD_VALID = 1'b0;
    @(negedge PCLK);
    checks++;
    if (PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_access: got en=%b want 1", PENABLE); end
    #2 PRESET = 1'b1;
    #1;
    checks++;
    if (PSELx !== 1'b0 || PENABLE !== 1'b0 || CMD_READY !== 1'b0 || PADDR !== '0) begin
      errors++; $display("FAIL rstmid_drop: got sel=%b en=%b rdy=%b addr=%h want 0 0 0 0",
        PSELx, PENABLE, CMD_READY, PADDR);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      if (RSP_VALID !== 1'b0) no_rsp = 1'b0;
    end
    PRESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      if (RSP_VALID !== 1'b0 || PSELx !== 1'b0) no_rsp = 1'b0;
    end
    checks++;
    if (!no_rsp || CMD_READY !== 1'b1) begin
      errors++; $display("FAIL rstmid_after: got no_rsp=%b rdy=%b want 1 1", no_rsp, CMD_READY);
    end
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h24; PREADY = 1'b1; PRDATA = 32'h0000_0077;
    @(negedge PCLK);
    CMD_VALID = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    PREADY = 1'b0;
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h0000_0077 || RSP_ERR !== 1'b0 || PADDR !== 32'h24) begin
      errors++; $display("FAIL rstmid_read: got rv=%b rdata=%h err=%b addr=%h want 1 00000077 0 24",
        RSP_VALID, RSP_RDATA, RSP_ERR, PADDR);
    end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
